// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait handling with a timeout escape and performance counters.
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_uses_rt_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rt_i,
    input  logic        mem_branch_i,
    input  logic        mem_zero_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        if_id_write_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_flush_o,
    output logic        pipe_hold_o,
    output logic [1:0]  state_o,
    output logic        timeout_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        timeout_q, timeout_set;
    logic        br_inc;
    logic [15:0] stall_q, flush_q;

    logic taken, load_use, mem_stall;

    assign taken     = mem_branch_i & mem_zero_i;
    assign load_use  = ex_memread_i & (ex_rt_i != 5'd0) &
                       ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
    assign mem_stall = mem_req_i & ~mem_ready_i;

    // State, wait counter and timeout flag register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_RUN;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_q | timeout_set;
        end
    end

    // Next-state: memory stall wins over branch, which wins over load-use
    always_comb begin
        state_d     = S_RUN;
        wait_d      = wait_q;
        timeout_set = 1'b0;
        br_inc      = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (mem_ready_i) begin
                    state_d = S_RUN;
                    wait_d  = 8'd0;
                end else if (wait_q == 8'hFF) begin
                    // give up on the access; the EX/MEM op is killed
                    timeout_set = 1'b1;
                    state_d     = S_RUN;
                    wait_d      = 8'd0;
                end else begin
                    state_d = S_WAIT;
                    wait_d  = wait_q + 8'd1;
                end
            end
            S_FLUSH: begin
                if (mem_stall) begin
                    state_d = S_WAIT;
                    wait_d  = 8'd1;
                end
            end
            default: begin  // RUN and the unused encoding
                if (mem_stall) begin
                    state_d = S_WAIT;
                    wait_d  = 8'd1;
                end else if (taken) begin
                    state_d = S_FLUSH;
                    br_inc  = 1'b1;
                end
            end
        endcase
    end

    // Control outputs from registered state and live hazard inputs
    always_comb begin
        pc_write_o     = 1'b1;
        pc_src_o       = 1'b0;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        pipe_hold_o    = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (!mem_ready_i) begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        if (wait_q == 8'hFF) ex_mem_flush_o = 1'b1;
                        else                 pipe_hold_o    = 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (mem_stall) begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        pipe_hold_o   = 1'b1;
                    end
                end
                default: begin
                    if (mem_stall) begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        pipe_hold_o   = 1'b1;
                    end else if (taken) begin
                        pc_src_o       = 1'b1;
                        if_id_flush_o  = 1'b1;
                        id_ex_flush_o  = 1'b1;
                        ex_mem_flush_o = 1'b1;
                    end else if (load_use) begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        id_ex_flush_o = 1'b1;
                    end
                end
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            if (!pc_write_o && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (br_inc && flush_q != 16'hFFFF)      flush_q <= flush_q + 16'd1;
        end
    end

    assign state_o     = state_q;
    assign timeout_o   = timeout_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: behavioural model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_memread, mem_branch, mem_zero, mem_req, mem_ready;
    logic        pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold;
    logic [1:0]  state;
    logic        timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .mem_branch_i(mem_branch), .mem_zero_i(mem_zero),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write), .pc_src_o(pc_src), .if_id_write_o(if_id_write),
        .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush), .ex_mem_flush_o(ex_mem_flush),
        .pipe_hold_o(pipe_hold), .state_o(state), .timeout_o(timeout),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 running, 1 waiting on memory (waited = cycles spent stalled so far), 2 post-branch
    int m_mode = 0, m_waited = 0, m_sc = 0, m_fc = 0;
    bit m_to = 0;

    // expected controls {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, hold}
    function automatic logic [6:0] model_ctl();
        bit tk, lu, ms;
        tk = mem_branch && mem_zero;
        lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        ms = mem_req && !mem_ready;
        if (rst) return 7'b0000000;
        if (m_mode == 1) begin
            if (mem_ready)         return 7'b1010000;
            if (m_waited == 255)   return 7'b0000010;   // 256th stalled cycle: abort
            return 7'b0000001;
        end
        if (ms)                    return 7'b0000001;
        if (m_mode == 2)           return 7'b1010000;
        if (tk)                    return 7'b1111110;
        if (lu)                    return 7'b0000100;
        return 7'b1010000;
    endfunction

    always @(posedge clk) begin
        logic [6:0] c;
        c = model_ctl();
        if (rst) begin
            m_mode = 0; m_waited = 0; m_sc = 0; m_fc = 0; m_to = 0;
        end else begin
            if (!c[6] && m_sc < 65535) m_sc++;
            if (m_mode == 1) begin
                if (mem_ready) m_mode = 0;
                else if (m_waited == 255) begin m_mode = 0; m_to = 1; end
                else m_waited++;
            end else if (mem_req && !mem_ready) begin
                m_mode = 1; m_waited = 1;
            end else if (m_mode == 2) m_mode = 0;
            else if (mem_branch && mem_zero) begin
                m_mode = 2;
                if (m_fc < 65535) m_fc++;
            end
        end
    end

    // single compare process, every cycle
    always @(negedge clk) begin
        logic [6:0] c;
        c = model_ctl();
        chk("ctl", {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold}, c);
        chk("state", state, m_mode);
        chk("timeout", timeout, m_to);
        chk("stall_cnt", stall_cnt, m_sc);
        chk("flush_cnt", flush_cnt, m_fc);
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memread = 0; ex_rt = 0;
        mem_branch = 0; mem_zero = 0; mem_req = 0; mem_ready = 1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    int s0, f0;

    initial begin
        rst = 1; idle();
        step(); step();
        settle();
        chk("rst_pcw", pc_write, 0);
        chk("rst_state", state, 0);
        chk("rst_stall", stall_cnt, 0);
        step(); rst = 0; step();

        // load-use on rs
        ex_memread = 1; ex_rt = 8; id_rs = 8;
        settle();
        chk("lu_pcw", pc_write, 0);
        chk("lu_ifw", if_id_write, 0);
        chk("lu_idex", id_ex_flush, 1);
        step(); idle(); settle();
        chk("lu_cnt", stall_cnt, 1);
        chk("lu_state", state, 0);
        // r0 never a hazard
        ex_memread = 1; ex_rt = 0; id_rs = 0; settle();
        chk("r0_pcw", pc_write, 1);
        step();
        // rt hazard only when rt is actually read
        ex_rt = 9; id_rs = 3; id_rt = 9; id_uses_rt = 0; settle();
        chk("rt_unused", pc_write, 1);
        step(); id_uses_rt = 1; settle();
        chk("rt_used", pc_write, 0);
        step(); idle(); step();

        // taken branch, load-use present during FLUSH cycle
        mem_branch = 1; mem_zero = 1; settle();
        chk("br_src", pc_src, 1);
        chk("br_fl", {if_id_flush, id_ex_flush, ex_mem_flush}, 7);
        step(); idle(); ex_memread = 1; ex_rt = 8; id_rs = 8; settle();
        chk("br_state2", state, 2);
        chk("br_lu_ign", pc_write, 1);
        chk("br_cnt", flush_cnt, 1);
        step(); idle(); settle();
        chk("br_state0", state, 0);
        // untaken branch
        mem_branch = 1; mem_zero = 0; settle();
        chk("nt_src", pc_src, 0);
        step(); idle(); step();

        // 3-cycle memory wait
        s0 = stall_cnt;
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("mw_hold", pipe_hold, 1); step();
        end
        mem_ready = 1; settle();
        chk("mw_ready_hold", pipe_hold, 0);
        chk("mw_state1", state, 1);
        step(); idle(); settle();
        chk("mw_state0", state, 0);
        chk("mw_stalls", stall_cnt - s0, 3);

        // all three events: memory stall wins
        f0 = flush_cnt;
        mem_req = 1; mem_ready = 0; mem_branch = 1; mem_zero = 1;
        ex_memread = 1; ex_rt = 5; id_rs = 5; settle();
        chk("pr_hold", pipe_hold, 1);
        chk("pr_src", pc_src, 0);
        chk("pr_idex", id_ex_flush, 0);
        step(); idle(); settle();
        chk("pr_fc", flush_cnt, f0);
        step();

        // timeout: 255 held cycles, abort on the 256th
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 255; i++) step();
        settle();
        chk("to_exmem", ex_mem_flush, 1);
        chk("to_hold", pipe_hold, 0);
        chk("to_state_w", state, 1);
        step(); idle(); settle();
        chk("to_state", state, 0);
        chk("to_flag", timeout, 1);
        for (int i = 0; i < 5; i++) step();
        chk("to_sticky", timeout, 1);

        // reset mid wait with stall_cnt = 5
        rst = 1; step(); rst = 0;
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 5; i++) step();
        settle();
        chk("rm_sc5", stall_cnt, 5);
        chk("rm_wait", state, 1);
        rst = 1; settle();
        chk("rm_ctl", {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold}, 0);
        step(); settle();
        chk("rm_state", state, 0);
        chk("rm_sc0", stall_cnt, 0);
        chk("rm_to", timeout, 0);
        rst = 0; idle(); step();

        // mixed traffic, model-checked
        for (int i = 0; i < 400; i++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3)); id_uses_rt = 1'($urandom);
            ex_memread = 1'($urandom); mem_branch = 1'($urandom); mem_zero = 1'($urandom);
            mem_req = 1'($urandom); mem_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0; idle(); step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
